// File: rtl/wb_write_port.sv
// Register-file write-port arbiter: ALU writeback has priority, MDU results wait in a FIFO.
// Optional macro WB_WAW_SQUASH_EN kills queued MDU results overwritten by a later ALU write.
module wb_write_port #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_we,
    input  logic [AW-1:0]            alu_wa,
    input  logic [DW-1:0]            alu_wd,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [AW-1:0]            mdu_wa,
    input  logic [DW-1:0]            mdu_wd,
    output logic                     we3,
    output logic [AW-1:0]            wa3,
    output logic [DW-1:0]            wd3,
    output logic [(1<<AW)-1:0]       pending,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    // ent_q: entry still owes a register write (cleared on pop, and on kill when squash is enabled)
    logic [DEPTH-1:0] ent_q, ent_d;
    logic [AW-1:0]    wa_q [DEPTH];
    logic [DW-1:0]    wd_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             we3_q, we3_d;
    logic [AW-1:0]    wa3_q, wa3_d;
    logic [DW-1:0]    wd3_q, wd3_d;

    logic alu_req, push, pop, full;

    always_comb begin
        alu_req   = alu_we && (alu_wa != '0);
        full      = (cnt_q == FULL_CNT);
        mdu_ready = !full && !reset;
        push      = mdu_valid && mdu_ready && (mdu_wa != '0);
        pop       = !alu_req && (cnt_q != '0);
    end

    always_comb begin
        ent_d    = ent_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        we3_d    = 1'b0;
        wa3_d    = wa3_q;
        wd3_d    = wd3_q;

        if (alu_req) begin
            we3_d = 1'b1;
            wa3_d = alu_wa;
            wd3_d = alu_wd;
        end else if (pop) begin
            we3_d = ent_q[rd_ptr_q];
            wa3_d = wa_q[rd_ptr_q];
            wd3_d = wd_q[rd_ptr_q];
        end

        if (pop) begin
            ent_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end

`ifdef WB_WAW_SQUASH_EN
        if (alu_req) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wa_q[i] == alu_wa) ent_d[i] = 1'b0;
            end
        end
`endif

        // Push is applied after the kill so a same-cycle MDU entry survives as the younger write
        if (push) begin
            ent_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
        end else begin
            ent_q    <= ent_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wa_q[wr_ptr_q] <= mdu_wa;
            wd_q[wr_ptr_q] <= mdu_wd;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i]) pending[wa_q[i]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign we3     = we3_q;
    assign wa3     = wa3_q;
    assign wd3     = wd3_q;
    assign q_count = cnt_q;

endmodule

// File: doc/wb_write_port.md
# wb_write_port

Writeback-side driver of the register file's single write port (`we3`/`wa3`/`wd3`). It merges two result sources into one registered write per cycle. The in-order ALU/load writeback has absolute priority. Results from the long-latency multiply/divide unit (MDU) are held in a small FIFO until the port is free. A per-register pending mask lets the hazard unit stall readers of registers whose results are still queued.

## Interface
Parameters:
- `DEPTH`, 4 — MDU result queue entries (power of two, ≥2)
- `DW`, 32 — data width
- `AW`, 5 — register address width

Ports:
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — synchronous, active-high
- `alu_we` in 1 — ALU/load writeback request this cycle (no backpressure)
- `alu_wa` in AW — ALU destination register
- `alu_wd` in DW — ALU result
- `mdu_valid` in 1 — MDU result offered
- `mdu_ready` out 1 — queue can accept; transfer when `mdu_valid && mdu_ready`
- `mdu_wa` in AW — MDU destination register
- `mdu_wd` in DW — MDU result
- `we3` out 1 — register-file write enable (registered)
- `wa3` out AW — register-file write address (registered)
- `wd3` out DW — register-file write data (registered)
- `pending` out 2^AW — bit i set while a live queue entry targets register i; bit 0 always 0
- `q_count` out log2(DEPTH)+1 — occupied queue entries, including killed ones

## Operation
- Clock and reset: one clock. Reset is synchronous and active-high, on `reset` sampled at the rising edge of `clk`.
- Reset values:
  - `we3`=0, `wa3`=0, `wd3`=0
  - queue empty, `q_count`=0, `pending`=0
  - `mdu_ready`=0 while `reset` is high
  - reset mid-operation discards all queued entries; no write is issued for them.
- Register 0 writes are discarded from either source:
  - `alu_we` with `alu_wa`=0 is treated as no request.
  - An MDU transfer with `mdu_wa`=0 completes the handshake but is not enqueued.
- Queue: FIFO of {live, wa, wd}. `mdu_ready` = !full, based on registered occupancy only.
  - At full, a same-cycle pop does not raise `mdu_ready`. There is no fall-through.
- Arbitration each cycle, in priority order:
  1. valid ALU request → issue the ALU write;
  2. else queue non-empty → pop the head. A live head issues its write; a killed head is dropped and `we3`=0 next cycle;
  3. else `we3`=0 next cycle.
- Pointers: read and write pointers wrap modulo DEPTH. A push and a pop in the same cycle leave `q_count` unchanged.
- WAW squash (when enabled): a valid ALU request to register X clears `live` on every queued entry with wa==X.
  - An MDU entry pushed in the same cycle counts as younger and is not killed.
- `pending`: OR of the one-hot decode of wa over live entries. It updates the cycle after any push, pop or kill.
- MDU starvation under continuous ALU traffic is allowed. The hazard unit uses `mdu_ready`=0 to insert a bubble.

## Timing
- ALU request at cycle t → `we3`/`wa3`/`wd3` valid during t+1.
- MDU transfer at t → entry visible at t+1, so `pending` reflects it at t+1. Earliest write is during t+2.
- The queue drains at most one entry per cycle, and only in cycles with no ALU request.
- `mdu_ready` is combinational from registered state and `reset` only. It has no path from `mdu_valid` or `alu_we`.

## Configuration
- Macro `WB_WAW_SQUASH_EN`:
  - Defined: WAW squash as described. Killed entries drop out of `pending` but still occupy queue slots until popped.
  - Undefined: there is no `live` bit. All queued entries issue in FIFO order regardless of ALU writes. The hazard unit must use `pending` to stall any ALU write to a pending register.

## Test plan
- Reset, then `alu_we`=1, `alu_wa`=3, `alu_wd`=0x1234 at t → `we3`=1, `wa3`=3, `wd3`=0x1234 at t+1; `we3`=0 at t+2.
- Single MDU transfer wa=7, wd=0xCAFE at t with no ALU traffic → `pending[7]`=1 at t+1; write of reg 7 = 0xCAFE during t+2; `pending[7]`=0 at t+2.
- Four MDU pushes (wa 1..4) with `alu_we` held high → `q_count`=4, `mdu_ready`=0. Drop `alu_we` → writes to 1,2,3,4 in order on four consecutive cycles, and `mdu_ready`=1 again once `q_count`<4.
- Queue holds wa=5, then ALU write to reg 5 (=0xAA) → with `WB_WAW_SQUASH_EN`: `pending[5]` clears, and the final reg-5 value written is 0xAA with no later write to 5. Without it: the queued write to 5 issues after 0xAA.
- `alu_wa`=0 and an MDU transfer with wa=0 → `we3` stays 0, `q_count` stays 0.
- Three entries queued, then `reset` pulsed for one cycle → the next cycle shows `q_count`=0, `pending`=0, `we3`=0, and no queued writes ever issue.
